ddr_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared DDR2 command port (256-bit data, 28-bit address). It sits between the memory controller and two requesters: port 0 is the data cache, port 1 is the NPU/ROM loader. It grants requesters round-robin and holds each command on the DDR port until the controller answers. It returns the response to the owner only, and flags a stalled controller with a watchdog.

---
 rtl/ddr_port_arbiter.sv | 132 +++++++++++++
 tb/tb_ddr_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - two-port round-robin arbiter and sequencer for the shared DDR command port
// Holds one command on the DDR port until the controller answers, then returns the response to its owner.
module ddr_port_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_rw,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [DATA_W-1:0] req_rdata,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [15:0] WD_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  state_t              r_state;
  logic                r_last_grant;
  logic [15:0]         r_wd;
  logic [1:0]          r_req_ready;
  logic [DATA_W-1:0]   r_req_rdata;
  logic                r_mem_valid;
  logic                r_mem_rw;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [1:0]          r_grant;
  logic                r_busy;
  logic                r_err_timeout;

  logic                w_pick1;
  logic                w_rw;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_wd_expire;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    w_pick1 = req_valid[1] & (~req_valid[0] | ~r_last_grant);
    w_rw    = w_pick1 ? req_rw[1]  : req_rw[0];
    w_addr  = w_pick1 ? req_addr1  : req_addr0;
    w_wdata = w_pick1 ? req_wdata1 : req_wdata0;
    w_wd_expire = WD_EN && (r_wd == WD_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_wd          <= 16'd0;
      r_req_ready   <= 2'b00;
      r_req_rdata   <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_rw      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_grant       <= 2'b00;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_req_ready <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_mem_rw     <= w_rw;
            r_mem_addr   <= w_addr;
            r_mem_wdata  <= w_wdata;
            r_grant      <= w_pick1 ? 2'b10 : 2'b01;
            r_last_grant <= w_pick1;
            r_mem_valid  <= 1'b1;
            r_busy       <= 1'b1;
            r_wd         <= 16'd0;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A completion in the expiry cycle takes priority over the watchdog.
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_req_rdata <= mem_rdata;
            r_req_ready <= r_grant;
            r_state     <= S_DONE;
          end else if (w_wd_expire) begin
            r_err_timeout <= 1'b1;
            r_mem_valid   <= 1'b0;
            r_req_rdata   <= '0;
            r_req_ready   <= r_grant;
            r_state       <= S_DONE;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        S_DONE: begin
          // No arbitration here: the owner's valid is still high for this cycle.
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign req_rdata   = r_req_rdata;
  assign mem_valid   = r_mem_valid;
  assign mem_rw      = r_mem_rw;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - scoreboard bench for ddr_port_arbiter
module tb_ddr_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 256;

  typedef struct {
    logic [1:0]    grant;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            len;
  } cmd_t;

  typedef struct {
    logic [1:0]    port;
    logic [DW-1:0] rdata;
    logic          err;
    logic          prev_ready;
  } rsp_t;

  logic          clk, rst;
  logic          vld0, vld1, rw0, rw1;
  logic [1:0]    req_valid, req_rw;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    req_ready;
  logic [DW-1:0] req_rdata;
  logic          mem_valid, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [1:0]    grant;
  logic          busy, err_timeout;

  int            ctl_delay;
  logic          ctl_never;
  logic [DW-1:0] ctl_rdata;
  logic          edge_ready;
  int            pulses0, pulses1;
  int            checks, errors;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  assign req_valid = {vld1, vld0};
  assign req_rw    = {rw1, rw0};
  assign mem_rdata = ctl_rdata;

  ddr_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw),
    .req_addr0(addr0), .req_addr1(addr1),
    .req_wdata0(wdata0), .req_wdata1(wdata1),
    .req_ready(req_ready), .req_rdata(req_rdata),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .busy(busy), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Controller: answers on the ctl_delay-th cycle of a command unless ctl_never.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        cnt++;
        mem_ready = (!ctl_never && cnt == ctl_delay);
      end else begin
        cnt = 0;
        mem_ready = 1'b0;
      end
    end
  end

  always @(posedge clk) edge_ready = mem_ready;

  // Command monitor: checks each command presented on the DDR port.
  initial begin
    logic prev_v;
    int   hi;
    cmd_t cur;
    prev_v = 1'b0;
    hi = 0;
    cur = '{grant: 2'b00, rw: 1'b0, addr: '0, wdata: '0, len: 0};
    forever begin
      @(negedge clk);
      if (mem_valid && !prev_v) begin
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd", 1, 0);
        end else begin
          cur = cmd_q.pop_front();
          chk("cmd_grant", DW'(grant), DW'(cur.grant));
          chk("cmd_rw", DW'(mem_rw), DW'(cur.rw));
          chk("cmd_addr", DW'(mem_addr), DW'(cur.addr));
          chk("cmd_wdata", mem_wdata, cur.wdata);
          chk("cmd_busy", DW'(busy), 1);
        end
        hi = 1;
      end else if (mem_valid) begin
        hi++;
        chk("cmd_addr_hold", DW'(mem_addr), DW'(cur.addr));
      end else if (prev_v && cur.len != 0) begin
        chk("cmd_len", DW'(hi), DW'(cur.len));
      end
      prev_v = mem_valid;
    end
  end

  // Response monitor: every req_ready pulse must match the next expected response.
  initial begin
    rsp_t r;
    pulses0 = 0;
    pulses1 = 0;
    forever begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        if (req_ready[0]) pulses0++;
        if (req_ready[1]) pulses1++;
        if (rsp_q.size() == 0) begin
          chk("unexpected_ready", DW'(req_ready), 0);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_port", DW'(req_ready), DW'(r.port));
          chk("rsp_rdata", req_rdata, r.rdata);
          chk("rsp_err", DW'(err_timeout), DW'(r.err));
          chk("rsp_after_mem_ready", DW'(edge_ready), DW'(r.prev_ready));
          chk("rsp_mem_valid_low", DW'(mem_valid), 0);
        end
      end
    end
  end

  task automatic serve(input int p);
    bit got;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        got = 1;
        break;
      end
    end
    if (!got) chk($sformatf("serve_timeout_p%0d", p), 0, 1);
    @(posedge clk);
    #1;
    if (p == 0) vld0 = 1'b0;
    else vld1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    vld0 = 0; vld1 = 0; rw0 = 0; rw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    ctl_delay = 1; ctl_never = 1'b0; ctl_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", DW'(mem_valid), 0);
    chk("rst_mem_rw", DW'(mem_rw), 0);
    chk("rst_mem_addr", DW'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_req_ready", DW'(req_ready), 0);
    chk("rst_req_rdata", req_rdata, 0);
    chk("rst_grant", DW'(grant), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_err", DW'(err_timeout), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single write on port 0, controller answers in the 4th cycle
    ctl_delay = 4;
    ctl_rdata = {8{32'hDEADBEEF}};
    cmd_q.push_back('{grant: 2'b01, rw: 1'b1, addr: 28'h1000000, wdata: {32{8'hA5}}, len: 4});
    rsp_q.push_back('{port: 2'b01, rdata: {8{32'hDEADBEEF}}, err: 1'b0, prev_ready: 1'b1});
    rw0 = 1; addr0 = 28'h1000000; wdata0 = {32{8'hA5}}; vld0 = 1;
    @(negedge clk);
    chk("lat_mem_valid", DW'(mem_valid), 1);
    serve(0);
    @(negedge clk);
    chk("idle_grant", DW'(grant), 0);

    // Read on port 1
    ctl_delay = 2;
    ctl_rdata = {16{16'h1234}};
    cmd_q.push_back('{grant: 2'b10, rw: 1'b0, addr: 28'h0000040, wdata: {8{32'h0BADF00D}}, len: 2});
    rsp_q.push_back('{port: 2'b10, rdata: {16{16'h1234}}, err: 1'b0, prev_ready: 1'b1});
    rw1 = 0; addr1 = 28'h0000040; wdata1 = {8{32'h0BADF00D}}; vld1 = 1;
    serve(1);
    @(negedge clk);

    // Requester address changes while the command is on the DDR port
    ctl_delay = 5;
    ctl_rdata = {8{32'h5555AAAA}};
    cmd_q.push_back('{grant: 2'b01, rw: 1'b0, addr: 28'h0000100, wdata: {32{8'h3C}}, len: 5});
    rsp_q.push_back('{port: 2'b01, rdata: {8{32'h5555AAAA}}, err: 1'b0, prev_ready: 1'b1});
    rw0 = 0; addr0 = 28'h0000100; wdata0 = {32{8'h3C}}; vld0 = 1;
    @(negedge clk);
    @(negedge clk);
    addr0 = 28'hFFFFFFF;
    serve(0);
    @(negedge clk);

    // Asynchronous reset in the middle of a command
    ctl_never = 1'b1;
    cmd_q.push_back('{grant: 2'b10, rw: 1'b0, addr: 28'h0000055, wdata: {8{32'h77777777}}, len: 0});
    rw1 = 0; addr1 = 28'h0000055; wdata1 = {8{32'h77777777}}; vld1 = 1;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    vld1 = 0;
    #1;
    chk("async_rst_mem_valid", DW'(mem_valid), 0);
    chk("async_rst_grant", DW'(grant), 0);
    chk("async_rst_busy", DW'(busy), 0);
    chk("async_rst_mem_addr", DW'(mem_addr), 0);
    chk("async_rst_req_ready", DW'(req_ready), 0);
    @(negedge clk);
    chk("async_rst_no_pulse", DW'(req_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    ctl_never = 1'b0;
    @(negedge clk);

    // Both ports continuously valid: grants alternate starting at port 0
    ctl_delay = 2;
    ctl_rdata = {8{32'hCAFE0000}};
    for (int k = 0; k < 3; k++) begin
      cmd_q.push_back('{grant: 2'b01, rw: 1'b1, addr: 28'h200 + 28'(k), wdata: {8{32'hA0000000 + 32'(k)}}, len: 2});
      rsp_q.push_back('{port: 2'b01, rdata: {8{32'hCAFE0000}}, err: 1'b0, prev_ready: 1'b1});
      cmd_q.push_back('{grant: 2'b10, rw: 1'b0, addr: 28'h300 + 28'(k), wdata: {8{32'hB0000000 + 32'(k)}}, len: 2});
      rsp_q.push_back('{port: 2'b10, rdata: {8{32'hCAFE0000}}, err: 1'b0, prev_ready: 1'b1});
    end
    pulses0 = 0;
    pulses1 = 0;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          rw0 = 1; addr0 = 28'h200 + 28'(k); wdata0 = {8{32'hA0000000 + 32'(k)}}; vld0 = 1;
          serve(0);
          @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          rw1 = 0; addr1 = 28'h300 + 28'(k); wdata1 = {8{32'hB0000000 + 32'(k)}}; vld1 = 1;
          serve(1);
          @(negedge clk);
        end
      end
    join
    repeat (4) @(negedge clk);
    chk("rr_pulses_p0", DW'(pulses0), 3);
    chk("rr_pulses_p1", DW'(pulses1), 3);

    // Watchdog: controller never answers
    ctl_never = 1'b1;
    cmd_q.push_back('{grant: 2'b01, rw: 1'b1, addr: 28'h0000777, wdata: {32{8'h11}}, len: 8});
    rsp_q.push_back('{port: 2'b01, rdata: '0, err: 1'b1, prev_ready: 1'b0});
    rw0 = 1; addr0 = 28'h0000777; wdata0 = {32{8'h11}}; vld0 = 1;
    serve(0);
    @(negedge clk);
    chk("wd_err_sticky", DW'(err_timeout), 1);
    ctl_never = 1'b0;
    ctl_delay = 3;
    rd = {8{32'h600DF00D}};
    ctl_rdata = rd;
    cmd_q.push_back('{grant: 2'b10, rw: 1'b0, addr: 28'h0000888, wdata: {32{8'h22}}, len: 3});
    rsp_q.push_back('{port: 2'b10, rdata: rd, err: 1'b1, prev_ready: 1'b1});
    rw1 = 0; addr1 = 28'h0000888; wdata1 = {32{8'h22}}; vld1 = 1;
    serve(1);
    repeat (3) @(negedge clk);

    chk("cmd_queue_drained", DW'(cmd_q.size()), 0);
    chk("rsp_queue_drained", DW'(rsp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
